// File: rtl/ddr5_phy_crc_pkg.sv
// Shared constants, FSM state type and the CRC-8 (x^8+x^2+x+1) byte-step function
// for the DDR5 write-CRC generator.
package ddr5_phy_crc_pkg;

  localparam int         CRC_W      = 8;
  localparam int         BEATS_BL16 = 8;
  localparam int         BEATS_BC8  = 4;
  localparam logic [7:0] PAD_BYTE   = 8'hFF;

  typedef enum logic {
    DATA = 1'b0,
    PAD  = 1'b1
  } crc_state_e;

  // One beat: eight serial CRC-8 shifts folded into a single XOR matrix.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] state,
                                                 input logic [CRC_W-1:0] data_byte);
    logic [CRC_W-1:0] x;
    logic [CRC_W-1:0] o;
    x    = state ^ data_byte;
    o[0] = x[0] ^ x[6] ^ x[7];
    o[1] = x[0] ^ x[1] ^ x[6];
    o[2] = x[0] ^ x[1] ^ x[2] ^ x[6];
    o[3] = x[1] ^ x[2] ^ x[3] ^ x[7];
    o[4] = x[2] ^ x[3] ^ x[4];
    o[5] = x[3] ^ x[4] ^ x[5];
    o[6] = x[4] ^ x[5] ^ x[6];
    o[7] = x[5] ^ x[6] ^ x[7];
    return o;
  endfunction

endpackage

// File: rtl/ddr5_phy_crc8_lane.sv
// One nibble lane of the DDR5 write-CRC generator: lane CRC state register plus
// the per-beat step, seeded from CRC_INIT on the first beat of every burst.
module ddr5_phy_crc8_lane
  import ddr5_phy_crc_pkg::*;
#(
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       load_init,
  input  logic       step_en,
  input  logic       pad_sel,
  input  logic [7:0] data_i,
  output logic [7:0] crc_next_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;
  logic [7:0] seed;
  logic [7:0] beat_byte;

  // Beat 0 ignores the stale state so bursts can run back to back.
  assign seed       = load_init ? CRC_INIT : state_q;
  assign beat_byte  = pad_sel ? PAD_BYTE : data_i;
  assign crc_next_o = crc8_step(seed, beat_byte);

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = '0;
    end else if (step_en) begin
      state_d = crc_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    state_q <= state_d;
  end

endmodule

// File: rtl/ddr5_phy_crc_gen.sv
// DDR5 write-CRC generator: one CRC-8 per nibble lane per BL16 / BC8 burst.
// Define DDR5_PHY_CRC_CHECK_EN to add crc_exp_i / crc_err_o for read-CRC checking.
module ddr5_phy_crc_gen
  import ddr5_phy_crc_pkg::*;
#(
  parameter int         NUM_LANES = 1,
  parameter logic [7:0] CRC_INIT  = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   clr_i,
  input  logic                   data_valid_i,
  input  logic                   bc8_i,
  input  logic [8*NUM_LANES-1:0] data_i,
  output logic                   ready_o,
  output logic                   crc_valid_o,
  output logic [8*NUM_LANES-1:0] crc_o
`ifdef DDR5_PHY_CRC_CHECK_EN
  ,
  input  logic [8*NUM_LANES-1:0] crc_exp_i,
  output logic [NUM_LANES-1:0]   crc_err_o
`endif
);

  localparam logic [2:0] LAST_BL16 = 3'(BEATS_BL16 - 1);
  localparam logic [2:0] LAST_BC8  = 3'(BEATS_BC8 - 1);
  localparam logic [2:0] LAST_PAD  = 3'(BEATS_BL16 - BEATS_BC8 - 1);

  if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_lanes
    $error("ddr5_phy_crc_gen: NUM_LANES must be 1, 2 or 4");
  end

  crc_state_e             state_q,     state_d;
  logic [2:0]             beat_cnt_q,  beat_cnt_d;
  logic [2:0]             pad_cnt_q,   pad_cnt_d;
  logic                   bc8_q,       bc8_d;
  logic                   crc_valid_q, crc_valid_d;
  logic [8*NUM_LANES-1:0] crc_q,       crc_d;

  logic                   load_init;
  logic                   step_en;
  logic                   pad_sel;
  logic                   burst_done;
  logic [8*NUM_LANES-1:0] lane_next;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    ddr5_phy_crc8_lane #(
      .CRC_INIT (CRC_INIT)
    ) u_lane (
      .clk_i      (clk_i),
      .clr_i      (clr_i),
      .load_init  (load_init),
      .step_en    (step_en),
      .pad_sel    (pad_sel),
      .data_i     (data_i[8*n +: 8]),
      .crc_next_o (lane_next[8*n +: 8])
    );
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    bc8_d      = bc8_q;
    load_init  = 1'b0;
    step_en    = 1'b0;
    pad_sel    = 1'b0;
    burst_done = 1'b0;

    if (clr_i) begin
      state_d    = DATA;
      beat_cnt_d = '0;
      pad_cnt_d  = '0;
      bc8_d      = 1'b0;
    end else begin
      unique case (state_q)
        DATA: begin
          if (data_valid_i) begin
            step_en   = 1'b1;
            load_init = (beat_cnt_q == 3'd0);
            if (beat_cnt_q == 3'd0) begin
              bc8_d = bc8_i;
            end
            // bc8_q is stale only on beat 0, where neither end-of-burst test can match.
            if (!bc8_q && beat_cnt_q == LAST_BL16) begin
              beat_cnt_d = '0;
              burst_done = 1'b1;
            end else if (bc8_q && beat_cnt_q == LAST_BC8) begin
              beat_cnt_d = '0;
              pad_cnt_d  = '0;
              state_d    = PAD;
            end else begin
              beat_cnt_d = beat_cnt_q + 3'd1;
            end
          end
        end
        PAD: begin
          step_en = 1'b1;
          pad_sel = 1'b1;
          if (pad_cnt_q == LAST_PAD) begin
            pad_cnt_d  = '0;
            bc8_d      = 1'b0;
            state_d    = DATA;
            burst_done = 1'b1;
          end else begin
            pad_cnt_d = pad_cnt_q + 3'd1;
          end
        end
        default: state_d = DATA;
      endcase
    end
  end

  always_comb begin
    crc_valid_d = burst_done;
    crc_d       = burst_done ? lane_next : crc_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= DATA;
      beat_cnt_q  <= '0;
      pad_cnt_q   <= '0;
      bc8_q       <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      bc8_q       <= bc8_d;
      crc_valid_q <= crc_valid_d;
      crc_q       <= crc_d;
    end
  end

  assign ready_o     = (state_q == DATA);
  assign crc_valid_o = crc_valid_q;
  assign crc_o       = crc_q;

`ifdef DDR5_PHY_CRC_CHECK_EN
  logic [NUM_LANES-1:0] crc_err_q, crc_err_d;

  // Expected CRC is sampled in the same cycle as the final lane update.
  always_comb begin
    crc_err_d = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      crc_err_d[n] = burst_done && (lane_next[8*n +: 8] != crc_exp_i[8*n +: 8]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_err_q <= '0;
    end else begin
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_err_o = crc_err_q;
`else
  // Generation-only build: no expected-CRC input and no error flags.
`endif

endmodule
